// File: rtl/mmio_mem_pkg.sv
// Shared definitions for the MMIO dual-port memory.
// Holds the address region type, the MMIO register offset map and the status bit positions.
package mmio_mem_pkg;

  typedef enum logic [1:0] {
    REGION_RAM      = 2'd0,
    REGION_UNMAPPED = 2'd1,
    REGION_MMIO     = 2'd2
  } memRegion_e;

  localparam int unsigned ST_FULL     = 0;
  localparam int unsigned ST_OVERRUN  = 1;
  localparam int unsigned ST_BUSY     = 0;
  localparam int unsigned UNMAPPED_RD = 0;

  // Per channel, the input window holds a data word followed by its status word.
  function automatic int inDataOff(input int k);
    return 2 * k;
  endfunction

  function automatic int inStatOff(input int k);
    return 2 * k + 1;
  endfunction

  function automatic int outDataOff(input int numIn, input int j);
    return 2 * numIn + j;
  endfunction

  function automatic int outStatOff(input int numIn, input int numOut, input int j);
    return 2 * numIn + numOut + j;
  endfunction

endpackage

// File: rtl/dp_ram_rf.sv
// True dual-port read-first RAM with registered read data.
// When both ports write the same word in one cycle, port A's data is stored.
module dp_ram_rf #(
  parameter int DATA_WIDTH = 16,
  parameter int RAM_AW     = 12
) (
  input  logic                  clk,
  input  logic                  weA,
  input  logic                  weB,
  input  logic [RAM_AW-1:0]     addrA,
  input  logic [RAM_AW-1:0]     addrB,
  input  logic [DATA_WIDTH-1:0] dA,
  input  logic [DATA_WIDTH-1:0] dB,
  output logic [DATA_WIDTH-1:0] qA,
  output logic [DATA_WIDTH-1:0] qB
);

  logic [DATA_WIDTH-1:0] mem [1 << RAM_AW];
  logic                  bBlocked;

  assign bBlocked = weA && (addrA == addrB);

  always_ff @(posedge clk) begin
    qA <= mem[addrA];
    qB <= mem[addrB];
    if (weB && !bBlocked) begin
      mem[addrB] <= dB;
    end
    if (weA) begin
      mem[addrA] <= dA;
    end
  end

endmodule

// File: rtl/mmio_dual_port_memory.sv
// Dual-port data memory with an MMIO window at the top of the address space:
// latched input channels with read-to-clear status and output channels with valid/ready.
module mmio_dual_port_memory
  import mmio_mem_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    RAM_AW     = 12,
  parameter int                    NUM_IN_CH  = 2,
  parameter int                    NUM_OUT_CH = 2,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 16'hFF00
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            dataA,
  input  logic [DATA_WIDTH-1:0]            dataB,
  input  logic [ADDR_WIDTH-1:0]            addressA,
  input  logic [ADDR_WIDTH-1:0]            addressB,
  input  logic                             writeEnableA,
  input  logic                             writeEnableB,
  output logic [DATA_WIDTH-1:0]            outputA,
  output logic [DATA_WIDTH-1:0]            outputB,
  input  logic [NUM_IN_CH*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_IN_CH-1:0]             in_valid,
  output logic [NUM_OUT_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT_CH-1:0]            out_valid,
  input  logic [NUM_OUT_CH-1:0]            out_ready,
  output logic                             collision
);

  localparam logic [ADDR_WIDTH:0] RAM_LIMIT = (ADDR_WIDTH + 1)'(1 << RAM_AW);

  logic [ADDR_WIDTH-1:0] addrP      [2];
  logic [DATA_WIDTH-1:0] wdataP     [2];
  logic                  weP        [2];
  memRegion_e            regionP    [2];
  logic [31:0]           offP       [2];
  logic [DATA_WIDTH-1:0] mmioRd     [2];
  logic [NUM_OUT_CH-1:0] outWr      [2];
  logic [DATA_WIDTH-1:0] ramQ       [2];

  logic [NUM_IN_CH-1:0]  popHit;
  logic [NUM_IN_CH-1:0]  statHit;
  logic [DATA_WIDTH-1:0] inData     [NUM_IN_CH];
  logic [NUM_IN_CH-1:0]  full;
  logic [NUM_IN_CH-1:0]  overrun;

  logic [DATA_WIDTH-1:0] outReg     [NUM_OUT_CH];
  logic [NUM_OUT_CH-1:0] outWrAny;
  logic [DATA_WIDTH-1:0] outWrData  [NUM_OUT_CH];

  logic                  ramWeA;
  logic                  ramWeB;
  logic                  collisionNext;
  logic                  ramSel_p1  [2];
  logic [DATA_WIDTH-1:0] mmioRd_p1  [2];

  assign addrP[0]  = addressA;
  assign addrP[1]  = addressB;
  assign wdataP[0] = dataA;
  assign wdataP[1] = dataB;
  assign weP[0]    = writeEnableA;
  assign weP[1]    = writeEnableB;

  // Address decode and MMIO read mux; a read strobe is any non-write access to the register.
  always_comb begin
    popHit  = '0;
    statHit = '0;
    for (int p = 0; p < 2; p++) begin
      offP[p]   = 32'(addrP[p] - MMIO_BASE);
      outWr[p]  = '0;
      mmioRd[p] = DATA_WIDTH'(UNMAPPED_RD);
      if ({1'b0, addrP[p]} < RAM_LIMIT) begin
        regionP[p] = REGION_RAM;
      end else if (addrP[p] >= MMIO_BASE) begin
        regionP[p] = REGION_MMIO;
      end else begin
        regionP[p] = REGION_UNMAPPED;
      end
      if (regionP[p] == REGION_MMIO) begin
        for (int k = 0; k < NUM_IN_CH; k++) begin
          if (offP[p] == 32'(inDataOff(k))) begin
            mmioRd[p] = inData[k];
            if (!weP[p]) popHit[k] = 1'b1;
          end
          if (offP[p] == 32'(inStatOff(k))) begin
            mmioRd[p]             = '0;
            mmioRd[p][ST_FULL]    = full[k];
            mmioRd[p][ST_OVERRUN] = overrun[k];
            if (!weP[p]) statHit[k] = 1'b1;
          end
        end
        for (int j = 0; j < NUM_OUT_CH; j++) begin
          if (offP[p] == 32'(outDataOff(NUM_IN_CH, j))) begin
            mmioRd[p]   = outReg[j];
            outWr[p][j] = weP[p];
          end
          if (offP[p] == 32'(outStatOff(NUM_IN_CH, NUM_OUT_CH, j))) begin
            mmioRd[p]          = '0;
            mmioRd[p][ST_BUSY] = out_valid[j];
          end
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_OUT_CH; j++) begin
      outWrAny[j]  = outWr[0][j] | outWr[1][j];
      outWrData[j] = outWr[0][j] ? wdataP[0] : wdataP[1];
      out_data[j*DATA_WIDTH +: DATA_WIDTH] = outReg[j];
    end
  end

  assign collisionNext = weP[0] && weP[1] && (addrP[0] == addrP[1]) &&
                         ((regionP[0] == REGION_RAM) || (|outWr[0]));

  assign ramWeA = !reset && weP[0] && (regionP[0] == REGION_RAM);
  assign ramWeB = !reset && weP[1] && (regionP[1] == REGION_RAM);

  dp_ram_rf #(
    .DATA_WIDTH(DATA_WIDTH),
    .RAM_AW    (RAM_AW)
  ) uRam (
    .clk  (clk),
    .weA  (ramWeA),
    .weB  (ramWeB),
    .addrA(addrP[0][RAM_AW-1:0]),
    .addrB(addrP[1][RAM_AW-1:0]),
    .dA   (wdataP[0]),
    .dB   (wdataP[1]),
    .qA   (ramQ[0]),
    .qB   (ramQ[1])
  );

  // Stage p1: registered read source select and MMIO read word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        ramSel_p1[p] <= 1'b0;
        mmioRd_p1[p] <= '0;
      end
      collision <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        ramSel_p1[p] <= (regionP[p] == REGION_RAM);
        mmioRd_p1[p] <= mmioRd[p];
      end
      collision <= collisionNext;
    end
  end

  assign outputA = ramSel_p1[0] ? ramQ[0] : mmioRd_p1[0];
  assign outputB = ramSel_p1[1] ? ramQ[1] : mmioRd_p1[1];

  // A capture racing a data read keeps full set and is not an overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_IN_CH; k++) begin
        inData[k] <= '0;
      end
      full    <= '0;
      overrun <= '0;
    end else begin
      for (int k = 0; k < NUM_IN_CH; k++) begin
        if (statHit[k]) begin
          overrun[k] <= 1'b0;
        end
        if (in_valid[k]) begin
          inData[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
          full[k]   <= 1'b1;
          if (full[k] && !popHit[k]) begin
            overrun[k] <= 1'b1;
          end
        end else if (popHit[k]) begin
          full[k] <= 1'b0;
        end
      end
    end
  end

  // A write is taken only when the slot is empty or being accepted this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NUM_OUT_CH; j++) begin
        outReg[j] <= '0;
      end
      out_valid <= '0;
    end else begin
      for (int j = 0; j < NUM_OUT_CH; j++) begin
        if (outWrAny[j] && (!out_valid[j] || out_ready[j])) begin
          outReg[j]    <= outWrData[j];
          out_valid[j] <= 1'b1;
        end else if (out_ready[j]) begin
          out_valid[j] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_dual_port_memory.sv
// Self-checking bench for mmio_dual_port_memory: expected read words are queued at stimulus time
// and compared against the outputs captured one clock later.
module tb_mmio_dual_port_memory;

  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int NIN  = 2;
  localparam int NOUT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   dataA, dataB, addressA, addressB;
  logic            writeEnableA, writeEnableB;
  logic [DW-1:0]   outputA, outputB;
  logic [NIN*DW-1:0]  in_data;
  logic [NIN-1:0]     in_valid;
  logic [NOUT*DW-1:0] out_data;
  logic [NOUT-1:0]    out_valid, out_ready;
  logic            collision;

  int vectors     = 0;
  int miscompares = 0;
  int cycleN      = 0;

  typedef struct {
    string         name;
    bit            portB;
    int            cyc;
    logic [DW-1:0] exp;
  } sb_t;

  sb_t           sb [$];
  logic [DW-1:0] obsA [int];
  logic [DW-1:0] obsB [int];

  mmio_dual_port_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_AW(12),
    .NUM_IN_CH(NIN), .NUM_OUT_CH(NOUT), .MMIO_BASE(16'hFF00)
  ) dut (
    .clk(clk), .reset(reset),
    .dataA(dataA), .dataB(dataB),
    .addressA(addressA), .addressB(addressB),
    .writeEnableA(writeEnableA), .writeEnableB(writeEnableB),
    .outputA(outputA), .outputB(outputB),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .collision(collision)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle();
    addressA = 16'h0100; addressB = 16'h0101;
    writeEnableA = 1'b0; writeEnableB = 1'b0;
    dataA = '0; dataB = '0;
    in_valid = '0;
  endtask

  task automatic setA(input logic [DW-1:0] a, input bit we, input logic [DW-1:0] d);
    addressA = a; writeEnableA = we; dataA = d;
  endtask

  task automatic setB(input logic [DW-1:0] a, input bit we, input logic [DW-1:0] d);
    addressB = a; writeEnableB = we; dataB = d;
  endtask

  task automatic expA(input string n, input logic [DW-1:0] v);
    sb.push_back('{n, 1'b0, cycleN + 1, v});
  endtask

  task automatic expB(input string n, input logic [DW-1:0] v);
    sb.push_back('{n, 1'b1, cycleN + 1, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycleN++;
    obsA[cycleN] = outputA;
    obsB[cycleN] = outputB;
    idle();
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = '0; in_data = '0; idle();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (outputA !== 16'h0) begin miscompares++; $display("FAIL reset_outputA: got %h want 0000", outputA); end
    vectors++; if (outputB !== 16'h0) begin miscompares++; $display("FAIL reset_outputB: got %h want 0000", outputB); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    vectors++; if (out_valid !== '0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 00", out_valid); end
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("FAIL reset_collision: got %b want 0", collision); end
    reset = 1'b0;
    setA(16'hFF01, 0, 0); setB(16'hFF03, 0, 0);
    expA("reset_in_stat0", 16'h0000); expB("reset_in_stat1", 16'h0000);
    step();
    while (sb.size() != 0) begin
      sb_t e; logic [DW-1:0] got;
      e = sb.pop_front(); vectors++;
      got = e.portB ? obsB[e.cyc] : obsA[e.cyc];
      if (got !== e.exp) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_ram_rw();
    setA(16'h0000, 1, 16'h0A0A); setB(16'h0FFF, 1, 16'hBEEF); step();
    setA(16'h000C, 1, 16'h0C0C); setB(16'h000D, 1, 16'h0D0D); step();
    setA(16'h000A, 1, 16'h0005); setB(16'h000B, 1, 16'h000A); step();
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("FAIL no_collision_diff_addr: got %b want 0", collision); end
    setA(16'h000A, 0, 0); setB(16'h000B, 0, 0);
    expA("ram_rd_a10", 16'h0005); expB("ram_rd_b11", 16'h000A); step();
    setA(16'h000C, 0, 0); setB(16'h000D, 0, 0);
    expA("ram_rd_a12", 16'h0C0C); expB("ram_rd_b13", 16'h0D0D); step();
    setA(16'h2000, 0, 0); setB(16'h2000, 1, 16'h5555);
    expA("unmapped_rd_2000", 16'h0000); step();
    setA(16'h0FFF, 0, 0); setB(16'h1000, 1, 16'h1234);
    expA("ram_top_word", 16'hBEEF); expB("unmapped_low_edge", 16'h0000); step();
    setA(16'h0000, 0, 0); setB(16'h8000, 0, 0);
    expA("unmapped_write_no_alias", 16'h0A0A); expB("unmapped_mid", 16'h0000); step();
    setA(16'h001E, 1, 16'h0030); step();
    setA(16'h001E, 1, 16'h0031); setB(16'h001E, 0, 0);
    expA("read_first_same_port", 16'h0030); expB("read_first_cross_port", 16'h0030); step();
    setA(16'h001E, 0, 0); expA("read_after_write", 16'h0031); step();
    while (sb.size() != 0) begin
      sb_t e; logic [DW-1:0] got;
      e = sb.pop_front(); vectors++;
      got = e.portB ? obsB[e.cyc] : obsA[e.cyc];
      if (got !== e.exp) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_collision();
    setA(16'h0014, 1, 16'h1111); setB(16'h0014, 1, 16'h2222); step();
    vectors++; if (collision !== 1'b1) begin miscompares++; $display("FAIL collision_pulse: got %b want 1", collision); end
    step();
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("FAIL collision_one_cycle: got %b want 0", collision); end
    setA(16'h0014, 0, 0); expA("collision_a_wins", 16'h1111); step();
    while (sb.size() != 0) begin
      sb_t e; logic [DW-1:0] got;
      e = sb.pop_front(); vectors++;
      got = e.portB ? obsB[e.cyc] : obsA[e.cyc];
      if (got !== e.exp) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_in_capture();
    in_data[15:0] = 16'd20; in_valid = 2'b01; step();
    in_data[15:0] = 16'd21; in_valid = 2'b01; step();
    setA(16'hFF01, 0, 0); expA("in_stat_overrun", 16'h0003); step();
    setA(16'hFF01, 0, 0); expA("in_stat_overrun_cleared", 16'h0001); step();
    setA(16'hFF00, 0, 0); expA("in_data_latest", 16'd21); step();
    setA(16'hFF01, 0, 0); expA("in_stat_after_pop", 16'h0000); step();
    while (sb.size() != 0) begin
      sb_t e; logic [DW-1:0] got;
      e = sb.pop_front(); vectors++;
      got = e.portB ? obsB[e.cyc] : obsA[e.cyc];
      if (got !== e.exp) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_pop_race();
    in_data[31:16] = 16'd39; in_valid = 2'b10; step();
    in_data[31:16] = 16'd40; in_valid = 2'b10;
    setA(16'hFF02, 0, 0); expA("pop_race_old_word", 16'd39); step();
    setA(16'hFF03, 0, 0); expA("pop_race_stat", 16'h0001); step();
    setA(16'hFF02, 0, 0); setB(16'hFF02, 0, 0);
    expA("dual_pop_a", 16'd40); expB("dual_pop_b", 16'd40); step();
    setA(16'hFF03, 0, 0); expA("dual_pop_stat", 16'h0000); step();
    while (sb.size() != 0) begin
      sb_t e; logic [DW-1:0] got;
      e = sb.pop_front(); vectors++;
      got = e.portB ? obsB[e.cyc] : obsA[e.cyc];
      if (got !== e.exp) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_out_handshake();
    out_ready = 2'b00;
    setA(16'hFF04, 1, 16'hABCD); step();
    vectors++; if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL out_valid_set: got %b want 1", out_valid[0]); end
    vectors++; if (out_data[15:0] !== 16'hABCD) begin miscompares++; $display("FAIL out_data_load: got %h want abcd", out_data[15:0]); end
    setA(16'hFF04, 1, 16'h1234); step();
    vectors++; if (out_data[15:0] !== 16'hABCD) begin miscompares++; $display("FAIL out_write_dropped: got %h want abcd", out_data[15:0]); end
    setA(16'hFF06, 0, 0); setB(16'hFF04, 0, 0);
    expA("out_stat_busy", 16'h0001); expB("out_data_rd", 16'hABCD); step();
    out_ready = 2'b01; step();
    vectors++; if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL out_accept_clears: got %b want 0", out_valid[0]); end
    out_ready = 2'b00;
    setA(16'hFF06, 0, 0); expA("out_stat_idle", 16'h0000); step();
    setA(16'hFF04, 1, 16'h1111); step();
    out_ready = 2'b01; setA(16'hFF04, 1, 16'h2222); step();
    out_ready = 2'b00;
    vectors++; if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL out_accept_write_valid: got %b want 1", out_valid[0]); end
    vectors++; if (out_data[15:0] !== 16'h2222) begin miscompares++; $display("FAIL out_accept_write_data: got %h want 2222", out_data[15:0]); end
    setA(16'hFF05, 1, 16'hAAAA); setB(16'hFF05, 1, 16'hBBBB); step();
    vectors++; if (out_data[31:16] !== 16'hAAAA) begin miscompares++; $display("FAIL out_dual_write_a_wins: got %h want aaaa", out_data[31:16]); end
    vectors++; if (collision !== 1'b1) begin miscompares++; $display("FAIL out_dual_write_collision: got %b want 1", collision); end
    while (sb.size() != 0) begin
      sb_t e; logic [DW-1:0] got;
      e = sb.pop_front(); vectors++;
      got = e.portB ? obsB[e.cyc] : obsA[e.cyc];
      if (got !== e.exp) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  task automatic test_async_reset();
    setA(16'h0029, 1, 16'h4141); setB(16'h0028, 1, 16'h4040); step();
    in_data[15:0] = 16'h0077; in_valid = 2'b01;
    setA(16'h0029, 1, 16'h9999); setB(16'h0029, 1, 16'h8888); step();
    vectors++; if (out_valid !== 2'b11) begin miscompares++; $display("FAIL pre_reset_pending: got %b want 11", out_valid); end
    vectors++; if (outputA !== 16'h4141) begin miscompares++; $display("FAIL pre_reset_outputA: got %h want 4141", outputA); end
    #3;
    reset = 1'b1;
    #1;
    vectors++; if (outputA !== 16'h0) begin miscompares++; $display("FAIL async_reset_outputA: got %h want 0000", outputA); end
    vectors++; if (outputB !== 16'h0) begin miscompares++; $display("FAIL async_reset_outputB: got %h want 0000", outputB); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL async_reset_out_data: got %h want 0", out_data); end
    vectors++; if (out_valid !== '0) begin miscompares++; $display("FAIL async_reset_out_valid: got %b want 00", out_valid); end
    vectors++; if (collision !== 1'b0) begin miscompares++; $display("FAIL async_reset_collision: got %b want 0", collision); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    setA(16'hFF01, 0, 0); setB(16'h0028, 0, 0);
    expA("reset_clears_full", 16'h0000); expB("ram_kept_over_reset", 16'h4040); step();
    setA(16'h0029, 0, 0); expA("ram_collision_word_kept", 16'h9999); step();
    while (sb.size() != 0) begin
      sb_t e; logic [DW-1:0] got;
      e = sb.pop_front(); vectors++;
      got = e.portB ? obsB[e.cyc] : obsA[e.cyc];
      if (got !== e.exp) begin miscompares++; $display("FAIL %s: got %h want %h", e.name, got, e.exp); end
    end
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_collision();
    test_in_capture();
    test_pop_race();
    test_out_handshake();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
